// File: rtl/sram_pkg.sv
// Shared types and helpers for the dual-port byte-enable SRAM: FSM encoding,
// parameter legality checks and the per-byte write-first merge.
package sram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam int BYTE_W = 8;

    function automatic bit read_latency_legal(input int rl);
        return (rl == 1) || (rl == 2);
    endfunction

    function automatic bit data_width_legal(input int dw);
        return (dw > 0) && ((dw % BYTE_W) == 0);
    endfunction

    // One byte lane of the write-first merge: new byte where enabled, else old.
    function automatic logic [BYTE_W-1:0] lane_merge(
        input logic [BYTE_W-1:0] old_b,
        input logic [BYTE_W-1:0] new_b,
        input logic              en
    );
        return en ? new_b : old_b;
    endfunction

endpackage

// File: rtl/sram_core_mem.sv
// Plain storage array: one byte-masked write port, one registered read port.
// Reads return the pre-write contents on a same-edge collision.
module sram_core_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 13,
    parameter int DEPTH      = 8192
) (
    input  logic                    clk_i,
    input  logic                    we_i,
    input  logic [ADDR_WIDTH-1:0]   waddr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wbe_i,
    input  logic                    re_i,
    input  logic [ADDR_WIDTH-1:0]   raddr_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (wbe_i[i]) begin
                    mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_dp_be.sv
// Dual-port SRAM wrapper: clear-after-reset engine, write-first bypass,
// out-of-range detection and a 1- or 2-cycle read pipeline around the array.
module sram_dp_be
    import sram_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 13,
    parameter int                    DEPTH          = 8192,
    parameter int                    READ_LATENCY   = 1,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                    sram_clk,
    input  logic                    sram_rst_n,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    rd_valid,
    output logic                    rd_ready,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_data_valid,
    output logic                    init_done,
    output logic                    addr_err
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    // One extra counter bit so DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LAST_W  = (ADDR_WIDTH+1)'(DEPTH - 1);

    if (!read_latency_legal(READ_LATENCY)) begin : g_bad_latency
        $error("sram_dp_be: READ_LATENCY must be 1 or 2");
    end
    if (!data_width_legal(DATA_WIDTH)) begin : g_bad_width
        $error("sram_dp_be: DATA_WIDTH must be a positive multiple of 8");
    end
    if (DEPTH > (2 ** ADDR_WIDTH)) begin : g_bad_depth
        $error("sram_dp_be: DEPTH exceeds the address space");
    end

    state_e                  state_q;
    logic [ADDR_WIDTH:0]     clr_cnt_q;
    logic                    init_done_q;
    logic                    addr_err_q;

    logic                    wr_acc, rd_acc, wr_oor, rd_oor, collide, clearing;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata, mem_rdata;
    logic [NUM_BYTES-1:0]    mem_wbe;

    logic                    vld_p0_q, vld_p1_q, rd_zero_p0_q;
    logic [NUM_BYTES-1:0]    byp_be_p0_q;
    logic [DATA_WIDTH-1:0]   byp_data_p0_q;
    logic [DATA_WIDTH-1:0]   rd_data_p1_d, rd_data_p1_q;

    assign wr_acc   = wr_valid & init_done_q;
    assign rd_acc   = rd_valid & init_done_q;
    assign wr_oor   = {1'b0, wr_addr} >= DEPTH_W;
    assign rd_oor   = {1'b0, rd_addr} >= DEPTH_W;
    assign collide  = wr_acc & rd_acc & ~wr_oor & (wr_addr == rd_addr);
    assign clearing = (state_q == ST_CLEAR);

    assign mem_we    = clearing | (wr_acc & ~wr_oor);
    assign mem_waddr = clearing ? clr_cnt_q[ADDR_WIDTH-1:0] : wr_addr;
    assign mem_wdata = clearing ? CLEAR_VALUE : wr_data;
    assign mem_wbe   = clearing ? {NUM_BYTES{1'b1}} : wr_be;

    always_ff @(posedge sram_clk) begin
        if (!sram_rst_n) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clr_cnt_q   <= '0;
            init_done_q <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            if (state_q == ST_CLEAR) begin
                clr_cnt_q <= clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_W) begin
                    state_q <= ST_RUN;
                end
            end else begin
                init_done_q <= 1'b1;
            end
            if ((wr_acc & wr_oor) | (rd_acc & rd_oor)) begin
                addr_err_q <= 1'b1;
            end
        end
    end

    sram_core_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk_i   (sram_clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .wbe_i   (mem_wbe),
        .re_i    (rd_acc),
        .raddr_i (rd_addr),
        .rdata_o (mem_rdata)
    );

    // Stage p0: array output plus the bypass/zero controls captured at acceptance.
    always_ff @(posedge sram_clk) begin
        if (!sram_rst_n) begin
            vld_p0_q     <= 1'b0;
            rd_zero_p0_q <= 1'b1;
            byp_be_p0_q  <= '0;
        end else begin
            vld_p0_q <= rd_acc;
            if (rd_acc) begin
                rd_zero_p0_q <= rd_oor;
                byp_be_p0_q  <= collide ? wr_be : '0;
            end
        end
    end

    always_ff @(posedge sram_clk) begin
        if (rd_acc) begin
            byp_data_p0_q <= wr_data;
        end
    end

    always_comb begin
        rd_data_p1_d = '0;
        if (!rd_zero_p0_q) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                rd_data_p1_d[8*i +: 8] = lane_merge(mem_rdata[8*i +: 8],
                                                    byp_data_p0_q[8*i +: 8],
                                                    byp_be_p0_q[i]);
            end
        end
    end

    // Stage p1: optional extra register for READ_LATENCY == 2.
    always_ff @(posedge sram_clk) begin
        if (!sram_rst_n) begin
            vld_p1_q     <= 1'b0;
            rd_data_p1_q <= '0;
        end else begin
            vld_p1_q <= vld_p0_q;
            if (vld_p0_q) begin
                rd_data_p1_q <= rd_data_p1_d;
            end
        end
    end

    assign rd_data       = (READ_LATENCY == 2) ? rd_data_p1_q : rd_data_p1_d;
    assign rd_data_valid = (READ_LATENCY == 2) ? vld_p1_q : vld_p0_q;
    assign wr_ready      = init_done_q;
    assign rd_ready      = init_done_q;
    assign init_done     = init_done_q;
    assign addr_err      = addr_err_q;

endmodule

// File: doc/sram_dp_be.md
Name: sram_dp_be

Overview:
- Parametrised successor to the single-port block SRAM: one write port and one read port, each with a valid/ready handshake.
- Adds per-byte write enables, selectable read latency (1 or 2 cycles) and a post-reset clear engine.
- Adds write-first bypass on same-address collisions and out-of-range address detection.
- Sits between the SPI/microSD loader (write side) and the boot core's fetch/data path (read side).

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 13, address bus width.
- DEPTH, 8192, number of words; must be ≤ 2^ADDR_WIDTH.
- READ_LATENCY, 1, cycles from read acceptance to data; legal values are 1 and 2.
- CLEAR_ON_RESET, 1, when 1, memory is filled with CLEAR_VALUE after reset.
- CLEAR_VALUE, 0, fill word used by the clear engine.

Ports:
- sram_clk, in, 1, single clock; all logic is rising-edge.
- sram_rst_n, in, 1, reset; synchronous, active-low.
- wr_valid, in, 1, write request.
- wr_ready, out, 1, write port can accept a request.
- wr_addr, in, ADDR_WIDTH, write word address.
- wr_data, in, DATA_WIDTH, write data.
- wr_be, in, DATA_WIDTH/8, byte enables; bit i controls data bits [8i+7:8i].
- rd_valid, in, 1, read request.
- rd_ready, out, 1, read port can accept a request.
- rd_addr, in, ADDR_WIDTH, read word address.
- rd_data, out, DATA_WIDTH, read data; holds its value between responses.
- rd_data_valid, out, 1, one-cycle pulse when rd_data carries a new response.
- init_done, out, 1, clear finished and ports open.
- addr_err, out, 1, sticky flag; set on any accepted access with address ≥ DEPTH.

Behaviour:
- Reset (sram_rst_n=0 sampled at a clock edge):
  - init_done=0, wr_ready=0, rd_ready=0.
  - rd_data=0, rd_data_valid=0, addr_err=0.
  - Read pipeline is flushed; clear counter is set to 0.
  - Memory contents are not reset directly.
- FSM has two states, CLEAR and RUN.
  - On reset release, FSM enters CLEAR if CLEAR_ON_RESET=1, otherwise RUN.
- CLEAR state:
  - Writes CLEAR_VALUE to address clr_cnt, one word per cycle, clr_cnt from 0 to DEPTH-1.
  - After the write to DEPTH-1, moves to RUN. init_done rises the cycle after that final write, so the clear takes DEPTH cycles plus 1.
  - wr_valid and rd_valid are ignored.
  - Reset mid-clear restarts the clear at address 0.
- RUN state:
  - wr_ready = rd_ready = init_done = 1. No back-pressure exists after initialisation.
- Write acceptance (wr_valid & wr_ready):
  - Only bytes with wr_be[i]=1 are updated, at the same edge.
  - wr_be=0 is accepted with no memory change.
- Read acceptance (rd_valid & rd_ready):
  - With READ_LATENCY=1, rd_data and rd_data_valid=1 appear after the next edge.
  - With READ_LATENCY=2, one extra register stage is added.
  - Back-to-back reads give one response per cycle, in order.
- Same-cycle write and read to the same in-range address (write-first):
  - rd_data returns wr_data for enabled bytes and the old memory bytes for disabled bytes.
- Out-of-range address (addr ≥ DEPTH):
  - Write is accepted and dropped; memory is unchanged.
  - Read is accepted and returns 0 with rd_data_valid=1 at normal latency.
  - Either case sets addr_err, which stays set until reset.
- Reset during an in-flight read: the response is discarded and no rd_data_valid pulse is produced.
- Address arithmetic: clr_cnt is ADDR_WIDTH+1 bits wide, so DEPTH = 2^ADDR_WIDTH does not wrap prematurely.

Decomposition:
- Package sram_pkg holds:
  - State encoding (ST_CLEAR, ST_RUN).
  - Legality checks on READ_LATENCY and DATA_WIDTH%8.
  - A function computing the byte-lane merge (old word, new word, byte enables).
- One sub-module: sram_core_mem.
  - Plain memory array with one byte-masked write port and one synchronous read port.
  - Instantiated once. The top holds the FSM, clear counter, bypass compare, range check and latency pipeline.

Test Plan:
- Reset release with CLEAR_ON_RESET=1, DEPTH=16 → init_done rises exactly 17 cycles later; reads of addresses 0..15 return 0x00000000.
- In RUN, write 0xDEADBEEF to addr 5 with be=4'b1111, then write 0x11223344 to addr 5 with be=4'b0101 → read of addr 5 returns 0xDE22BE44, one cycle after acceptance with READ_LATENCY=1.
- Same cycle: write 0xAABBCCDD with be=4'b0011 to addr 7 (old value 0x12345678) and read addr 7 → rd_data=0x1234CCDD; a later read also returns 0x1234CCDD.
- READ_LATENCY=2: back-to-back reads of addrs 1, 2, 3 holding 0x1, 0x2, 0x3 → rd_data_valid high on cycles +2, +3, +4 with rd_data 0x1, 0x2, 0x3 in order.
- DEPTH=12, ADDR_WIDTH=4: write to addr 13 and read addr 13 → memory unchanged, rd_data=0, addr_err=1 and stays 1 until sram_rst_n=0.
- Assert sram_rst_n=0 mid-clear at clr_cnt=9, and separately with a read in flight → clear restarts at 0 (init_done after DEPTH+1 cycles) and no rd_data_valid pulse for the flushed read.
